ysyx_23060236_csr_trap_unit: RTL and testbench
==============================================

YSYX_23060236_CSR_TRAP_UNIT -- requirements
Module: ysyx_23060236_csr_trap_unit

Interface
REQ-001 SHALL have parameters: NUM_IRQ, default 4, platform interrupt lines (1..16); CNT_W, default 64, mcycle/minstret width (32..64); VECTORED, default 1, enables mtvec vectored mode.
REQ-002 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-003 SHALL have ports: valid  in  1  instruction commit strobe; csr_addr  in  12  CSR address; csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC; csr_src  in  32  operand.
REQ-004 SHALL have ports: rdata  out  32  old CSR value; csr_illegal  out  1  csr_op!=00 with unimplemented address.
REQ-005 SHALL have ports: inst_ecall, inst_ebreak, inst_mret  in  1 each; exc_valid  in  1; exc_cause  in  5; exc_tval  in  32; epc  in  32  PC of committing instruction.
REQ-006 SHALL have ports: irq_meip, irq_mtip, irq_msip  in  1 each, synchronous; irq_plat  in  NUM_IRQ  asynchronous.
REQ-007 SHALL have ports: jump  out  32; jump_en  out  1; irq_take  out  1; mmu_on  out  1  satp[31]; ppn  out  20  satp[19:0].

Function
REQ-008 Implemented CSRs SHALL be: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, satp 180, mcycle B00, minstret B02, mcycleh B80, minstreth B82, mvendorid F11 (0x79737978), marchid F12 (0x015fdf0c).
REQ-009 rdata SHALL be combinational, old value; unimplemented addresses read 0.
REQ-010 New value SHALL be: RW src; RS old|src; RC old&~src; write only when valid, csr_op!=00, address writable, no trap this cycle.
REQ-011 mip SHALL be read-only: bit11 MEIP, bit7 MTIP, bit3 MSIP, bits 16+i platform line i; mie writable only at the same bits.
REQ-012 irq_plat SHALL pass a 2-flop synchroniser; assertion visible in mip exactly 2 cycles later.
REQ-013 Sync exception SHALL be exc_valid (cause exc_cause), inst_ecall (11, tval 0), inst_ebreak (3, tval epc); priority exc_valid > ebreak > ecall.
REQ-014 Interrupt pending SHALL be mstatus.MIE & |(mip&mie); selected cause priority 11 > 3 > 7 > 16+i (lowest i first).
REQ-015 At valid, priority SHALL be: sync exception > interrupt > mret > CSR write.
REQ-016 On any trap: mepc<=epc, mcause<={irq,cause}, MPIE<=MIE, MIE<=0, MPP<=11; exceptions write mtval, interrupts write mtval 0.
REQ-017 Interrupt SHALL abort the committing instruction: CSR write suppressed, minstret not incremented, irq_take=1.
REQ-018 mret SHALL set MIE<=MPIE, MPIE<=1, jump=mepc.
REQ-019 jump SHALL be {mtvec[31:2],00}, plus 4*cause for interrupts when VECTORED=1 and mtvec[0]=1; mtvec[1] hardwired 0, mtvec[0] hardwired 0 when VECTORED=0.
REQ-020 jump_en, irq_take SHALL be combinational, gated by valid, and 0 when valid=0.
REQ-021 mcycle SHALL increment every non-reset cycle; a write that cycle takes precedence (no increment); wraps at 2^CNT_W.
REQ-022 minstret SHALL increment on valid without trap; same write precedence and wrap.
REQ-023 Bits at or above CNT_W SHALL read 0 and ignore writes; mcycleh/minstreth read 0 when CNT_W=32.
REQ-024 mcause SHALL store bit31 and bits[4:0], others read 0; mepc[1:0] reads 0.

Reset
REQ-025 While reset=0, at each clock edge: mstatus<=0x1800, satp, mie, mepc, mcause, mtval, mtvec, mscratch, counters, synchroniser flops <=0.
REQ-026 Reset mid-trap SHALL take precedence; no CSR update from valid in that cycle.
REQ-027 Counters SHALL not increment during reset; the first increment occurs at the first edge with reset=1.

Structure
REQ-028 Package ysyx_23060236_csr_pkg SHALL hold CSR address constants, csr_op encoding, cause codes, mstatus bit positions.
REQ-029 Synchroniser SHALL be sub-module ysyx_23060236_irq_sync, width NUM_IRQ.

Verification
REQ-030 Reset, then read mstatus -> 0x1800; mcycle after 10 released cycles -> 10.
REQ-031 RS mstatus src=0x8, mie=0x80, irq_mtip=1, valid with epc=0x80000100 -> jump_en, irq_take, mcause=0x80000007, mepc=0x80000100, MIE=0, MPIE=1.
REQ-032 mtvec=0x80000001, irq_plat[2] rises, MIE/mie bit18 set -> taken 2 cycles later, jump=0x80000048.
REQ-033 ecall and irq_meip pending together at valid -> mcause=11, irq_take=0; then mret -> jump=mepc, MIE=1.
REQ-034 Write mcycle=0xFFFFFFFF_FFFFFFFF -> next cycle 0; CNT_W=32 -> mcycleh reads 0.
REQ-035 csr_op=RW to 0x7C0 -> csr_illegal=1, rdata=0, no state change.

Source files
------------

// File: rtl/ysyx_23060236_csr_pkg.sv
// CSR trap unit shared definitions: CSR addresses, csr_op encoding,
// trap cause codes, mstatus field positions and the CSR op helper.
package ysyx_23060236_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_SATP      = 12'h180;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h015f_df0c;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
  localparam logic [4:0] EXC_ECALL_M    = 5'd11;
  localparam logic [4:0] IRQ_MSI        = 5'd3;
  localparam logic [4:0] IRQ_MTI        = 5'd7;
  localparam logic [4:0] IRQ_MEI        = 5'd11;
  localparam int         IRQ_PLAT_BASE  = 16;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;
  localparam logic [31:0] MCAUSE_WMASK  = 32'h8000_001F;

  function automatic logic [31:0] csr_apply(
    input logic [1:0]  op,
    input logic [31:0] old,
    input logic [31:0] src
  );
    logic [31:0] r;
    case (op)
      OP_RW:   r = src;
      OP_RS:   r = old | src;
      OP_RC:   r = old & ~src;
      default: r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060236_irq_sync.sv
// Two-flop synchroniser for the asynchronous platform interrupt lines.
// Ports: clock, reset (sync, active-low), async_i (raw), sync_o (2 edges late).
module ysyx_23060236_irq_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ysyx_23060236_csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, interrupts and counters.
// Ports: clock/reset; CSR access (valid, csr_addr, csr_op, csr_src ->
// rdata, csr_illegal); trap inputs (inst_*, exc_*, epc, irq_*);
// redirect (jump, jump_en, irq_take); satp view (mmu_on, ppn).
module ysyx_23060236_csr_trap_unit
  import ysyx_23060236_csr_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int CNT_W    = 64,
  parameter int VECTORED = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_src,
  output logic [31:0]        rdata,
  output logic               csr_illegal,
  input  logic               inst_ecall,
  input  logic               inst_ebreak,
  input  logic               inst_mret,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic [31:0]        exc_tval,
  input  logic [31:0]        epc,
  input  logic               irq_meip,
  input  logic               irq_mtip,
  input  logic               irq_msip,
  input  logic [NUM_IRQ-1:0] irq_plat,
  output logic [31:0]        jump,
  output logic               jump_en,
  output logic               irq_take,
  output logic               mmu_on,
  output logic [19:0]        ppn
);

  localparam logic [31:0] MTVEC_WMASK =
    (VECTORED != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] satp_q, satp_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;

  logic [NUM_IRQ-1:0] plat_sync;
  logic [31:0] mip;
  logic [31:0] mie_wmask;
  logic [31:0] irq_vec;
  logic [4:0]  irq_cause;
  logic        irq_pend;

  logic        exc_any;
  logic [4:0]  exc_code;
  logic [31:0] exc_val;
  logic        take_exc;
  logic        take_irq;
  logic        trap;
  logic        do_mret;

  logic        csr_impl;
  logic        csr_wr_ok;
  logic        csr_we;
  logic [31:0] wdata;
  logic [63:0] mcycle_x;
  logic [63:0] minstret_x;
  logic [63:0] mcyc_n;
  logic [63:0] mins_n;
  logic [31:0] tvec_base;
  logic [31:0] vec_off;

  ysyx_23060236_irq_sync #(
    .W(NUM_IRQ)
  ) u_irq_sync (
    .clock  (clock),
    .reset  (reset),
    .async_i(irq_plat),
    .sync_o (plat_sync)
  );

  // Counters are handled as 64-bit views so the high halves simply
  // read zero (and drop writes) when CNT_W is narrower.
  assign mcycle_x   = 64'(mcycle_q);
  assign minstret_x = 64'(minstret_q);

  always_comb begin
    mip = '0;
    mip[IRQ_MEI] = irq_meip;
    mip[IRQ_MTI] = irq_mtip;
    mip[IRQ_MSI] = irq_msip;
    mip[IRQ_PLAT_BASE +: NUM_IRQ] = plat_sync;
    mie_wmask = '0;
    mie_wmask[IRQ_MEI] = 1'b1;
    mie_wmask[IRQ_MTI] = 1'b1;
    mie_wmask[IRQ_MSI] = 1'b1;
    mie_wmask[IRQ_PLAT_BASE +: NUM_IRQ] = '1;
  end

  assign irq_vec  = mip & mie_q;
  assign irq_pend = mstatus_q[MS_MIE] & (|irq_vec);

  // Later assignments win: platform lines lowest index first,
  // then MTI, MSI and finally MEI as the most urgent.
  always_comb begin
    irq_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_vec[IRQ_PLAT_BASE + i]) irq_cause = 5'(IRQ_PLAT_BASE + i);
    end
    if (irq_vec[IRQ_MTI]) irq_cause = IRQ_MTI;
    if (irq_vec[IRQ_MSI]) irq_cause = IRQ_MSI;
    if (irq_vec[IRQ_MEI]) irq_cause = IRQ_MEI;
  end

  assign exc_any = exc_valid | inst_ebreak | inst_ecall;

  always_comb begin
    unique case (1'b1)
      exc_valid: begin
        exc_code = exc_cause;
        exc_val  = exc_tval;
      end
      inst_ebreak: begin
        exc_code = EXC_BREAKPOINT;
        exc_val  = epc;
      end
      default: begin
        exc_code = EXC_ECALL_M;
        exc_val  = '0;
      end
    endcase
  end

  assign take_exc = valid & exc_any;
  assign take_irq = valid & ~exc_any & irq_pend;
  assign trap     = take_exc | take_irq;
  assign do_mret  = valid & inst_mret & ~trap;
  assign irq_take = take_irq;
  assign jump_en  = trap | do_mret;

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign vec_off   = {25'b0, irq_cause, 2'b00};

  always_comb begin
    if (do_mret) begin
      jump = mepc_q;
    end else if (take_irq && (VECTORED != 0) && mtvec_q[0]) begin
      jump = tvec_base + vec_off;
    end else begin
      jump = tvec_base;
    end
  end

  always_comb begin
    rdata     = '0;
    csr_impl  = 1'b1;
    csr_wr_ok = 1'b1;
    unique case (csr_addr)
      CSR_MSTATUS:   rdata = mstatus_q;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_SATP:      rdata = satp_q;
      CSR_MCYCLE:    rdata = mcycle_x[31:0];
      CSR_MINSTRET:  rdata = minstret_x[31:0];
      CSR_MCYCLEH:   rdata = mcycle_x[63:32];
      CSR_MINSTRETH: rdata = minstret_x[63:32];
      CSR_MIP: begin
        rdata     = mip;
        csr_wr_ok = 1'b0;
      end
      CSR_MVENDORID: begin
        rdata     = MVENDORID_VAL;
        csr_wr_ok = 1'b0;
      end
      CSR_MARCHID: begin
        rdata     = MARCHID_VAL;
        csr_wr_ok = 1'b0;
      end
      default: begin
        csr_impl  = 1'b0;
        csr_wr_ok = 1'b0;
      end
    endcase
  end

  assign csr_illegal = (csr_op != OP_NONE) & ~csr_impl;
  assign wdata       = csr_apply(csr_op, rdata, csr_src);
  // mret outranks a CSR write carried by the same commit.
  assign csr_we = valid & (csr_op != OP_NONE) & csr_wr_ok
                & ~trap & ~do_mret;

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    satp_d     = satp_q;
    mcyc_n     = mcycle_x + 64'd1;
    mins_n     = minstret_x + {63'b0, valid & ~trap};
    if (csr_we) begin
      unique case (csr_addr)
        CSR_MSTATUS:   mstatus_d  = wdata & MSTATUS_WMASK;
        CSR_MIE:       mie_d      = wdata & mie_wmask;
        CSR_MTVEC:     mtvec_d    = wdata & MTVEC_WMASK;
        CSR_MSCRATCH:  mscratch_d = wdata;
        CSR_MEPC:      mepc_d     = wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE:    mcause_d   = wdata & MCAUSE_WMASK;
        CSR_MTVAL:     mtval_d    = wdata;
        CSR_SATP:      satp_d     = wdata;
        CSR_MCYCLE:    mcyc_n = {mcycle_x[63:32], wdata};
        CSR_MCYCLEH:   mcyc_n = {wdata, mcycle_x[31:0]};
        CSR_MINSTRET:  mins_n = {minstret_x[63:32], wdata};
        CSR_MINSTRETH: mins_n = {wdata, minstret_x[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d   = epc & 32'hFFFF_FFFC;
      mcause_d = take_irq ? {1'b1, 26'b0, irq_cause}
                          : {1'b0, 26'b0, exc_code};
      mtval_d  = take_irq ? 32'h0 : exc_val;
      mstatus_d[MS_MPIE] = mstatus_q[MS_MIE];
      mstatus_d[MS_MIE]  = 1'b0;
      mstatus_d[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    end else if (do_mret) begin
      mstatus_d[MS_MIE]  = mstatus_q[MS_MPIE];
      mstatus_d[MS_MPIE] = 1'b1;
    end
    mcycle_d   = mcyc_n[CNT_W-1:0];
    minstret_d = mins_n[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mstatus_q  <= MSTATUS_RESET;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      satp_q     <= satp_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mmu_on = satp_q[31];
  assign ppn    = satp_q[19:0];

endmodule

// File: tb/tb_ysyx_23060236_csr_trap_unit.sv
// Bench for the CSR trap unit: directed scenarios plus random
// stimulus checked every cycle against a field-level model.
module tb_ysyx_23060236_csr_trap_unit;

  localparam int NIRQ = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_src = '0;
  logic        inst_ecall = 1'b0;
  logic        inst_ebreak = 1'b0;
  logic        inst_mret = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_tval = '0;
  logic [31:0] epc = '0;
  logic        irq_meip = 1'b0;
  logic        irq_mtip = 1'b0;
  logic        irq_msip = 1'b0;
  logic [NIRQ-1:0] irq_plat = '0;

  logic [31:0] rdata, jump;
  logic        csr_illegal, jump_en, irq_take, mmu_on;
  logic [19:0] ppn;
  logic [31:0] rdata32, jump32;
  logic        ill32, jen32, itake32, mmu32;
  logic [19:0] ppn32;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_23060236_csr_trap_unit #(
    .NUM_IRQ(NIRQ), .CNT_W(64), .VECTORED(1)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_src(csr_src),
    .rdata(rdata), .csr_illegal(csr_illegal),
    .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak),
    .inst_mret(inst_mret), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
    .irq_meip(irq_meip), .irq_mtip(irq_mtip), .irq_msip(irq_msip),
    .irq_plat(irq_plat), .jump(jump), .jump_en(jump_en),
    .irq_take(irq_take), .mmu_on(mmu_on), .ppn(ppn)
  );

  ysyx_23060236_csr_trap_unit #(
    .NUM_IRQ(NIRQ), .CNT_W(32), .VECTORED(1)
  ) dut32 (
    .clock(clock), .reset(reset), .valid(valid),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_src(csr_src),
    .rdata(rdata32), .csr_illegal(ill32),
    .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak),
    .inst_mret(inst_mret), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
    .irq_meip(irq_meip), .irq_mtip(irq_mtip), .irq_msip(irq_msip),
    .irq_plat(irq_plat), .jump(jump32), .jump_en(jen32),
    .irq_take(itake32), .mmu_on(mmu32), .ppn(ppn32)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit        m_ok = 1'b0;
  bit        m_mie_b, m_mpie_b;
  bit [1:0]  m_mpp;
  bit [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_satp;
  bit [63:0] m_cyc, m_ins;
  bit [NIRQ-1:0] plat_seen1, plat_seen2;

  localparam bit [31:0] M_MIE_MASK = 32'h000F_0888;

  function automatic bit [31:0] m_mstatus();
    return (32'(m_mpp) << 11) | (32'(m_mpie_b) << 7) | (32'(m_mie_b) << 3);
  endfunction

  function automatic bit [31:0] m_mip();
    bit [31:0] v;
    v = 32'(plat_seen2) << 16;
    if (irq_meip) v = v | 32'h800;
    if (irq_mtip) v = v | 32'h80;
    if (irq_msip) v = v | 32'h8;
    return v;
  endfunction

  function automatic bit [4:0] int_cause(input bit [31:0] p);
    if (p[11]) return 5'd11;
    if (p[3]) return 5'd3;
    if (p[7]) return 5'd7;
    for (int i = 0; i < NIRQ; i++) if (p[16+i]) return 5'(16 + i);
    return 5'd0;
  endfunction

  function automatic void m_read(input bit [11:0] a, output bit [31:0] v,
                                 output bit impl, output bit wok);
    impl = 1; wok = 1; v = 0;
    case (a)
      12'h300: v = m_mstatus();
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h180: v = m_satp;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'h344: begin v = m_mip(); wok = 0; end
      12'hF11: begin v = 32'h7973_7978; wok = 0; end
      12'hF12: begin v = 32'h015f_df0c; wok = 0; end
      default: begin impl = 0; wok = 0; end
    endcase
  endfunction

  function automatic void m_eval(output bit trap, output bit is_irq,
                                 output bit mret, output bit [4:0] cause,
                                 output bit [31:0] tval, output bit [31:0] jmp);
    bit [31:0] pend, base;
    trap = 0; is_irq = 0; mret = 0; cause = 0; tval = 0;
    base = m_mtvec & 32'hFFFF_FFFC;
    jmp = base;
    pend = m_mip() & m_mie;
    if (!valid) return;
    if (exc_valid || inst_ebreak || inst_ecall) begin
      trap = 1;
      if (exc_valid) begin cause = exc_cause; tval = exc_tval; end
      else if (inst_ebreak) begin cause = 3; tval = epc; end
      else begin cause = 11; tval = 0; end
    end else if (m_mie_b && pend != 0) begin
      trap = 1; is_irq = 1;
      cause = int_cause(pend);
      if (m_mtvec[0]) jmp = base + 32'(cause) * 4;
    end else if (inst_mret) begin
      mret = 1;
      jmp = m_mepc;
    end
  endfunction

  task automatic model_step();
    bit trap, is_irq, mret, impl, wok, we, cw, iw;
    bit [4:0] cause;
    bit [31:0] tval, jmp, old, nv;
    if (!reset) begin
      m_mie_b = 0; m_mpie_b = 0; m_mpp = 2'b11;
      m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_satp = 0; m_cyc = 0; m_ins = 0;
      plat_seen1 = 0; plat_seen2 = 0;
      m_ok = 1;
      return;
    end
    m_eval(trap, is_irq, mret, cause, tval, jmp);
    m_read(csr_addr, old, impl, wok);
    we = valid && csr_op != 0 && wok && !trap && !mret;
    case (csr_op)
      2'b01: nv = csr_src;
      2'b10: nv = old | csr_src;
      default: nv = old & ~csr_src;
    endcase
    cw = 0; iw = 0;
    if (we) begin
      case (csr_addr)
        12'h300: begin
          m_mie_b = nv[3]; m_mpie_b = nv[7]; m_mpp = nv[12:11];
        end
        12'h304: m_mie = nv & M_MIE_MASK;
        12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv & 32'h8000_001F;
        12'h343: m_mtval = nv;
        12'h180: m_satp = nv;
        12'hB00: begin m_cyc[31:0] = nv; cw = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cw = 1; end
        12'hB02: begin m_ins[31:0] = nv; iw = 1; end
        12'hB82: begin m_ins[63:32] = nv; iw = 1; end
        default: ;
      endcase
    end
    if (trap) begin
      m_mepc = epc & 32'hFFFF_FFFC;
      m_mcause = is_irq ? (32'h8000_0000 | 32'(cause)) : 32'(cause);
      m_mtval = is_irq ? 0 : tval;
      m_mpie_b = m_mie_b; m_mie_b = 0; m_mpp = 2'b11;
    end else if (mret) begin
      m_mie_b = m_mpie_b; m_mpie_b = 1;
    end
    if (!cw) m_cyc = m_cyc + 1;
    if (!iw && valid && !trap) m_ins = m_ins + 1;
    plat_seen2 = plat_seen1;
    plat_seen1 = irq_plat;
  endtask

  task automatic compare();
    bit trap, is_irq, mret, impl, wok;
    bit [4:0] cause;
    bit [31:0] tval, jmp, v;
    m_read(csr_addr, v, impl, wok);
    m_eval(trap, is_irq, mret, cause, tval, jmp);
    chk("rdata", rdata, 64'(v));
    chk("csr_illegal", csr_illegal, 64'(csr_op != 0 && !impl));
    chk("jump_en", jump_en, 64'(trap | mret));
    chk("irq_take", irq_take, 64'(is_irq));
    if (trap | mret) chk("jump", jump, 64'(jmp));
    chk("mmu_on", mmu_on, 64'(m_satp[31]));
    chk("ppn", ppn, 64'(m_satp[19:0]));
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_ok) compare();
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    valid = 0; csr_op = 0; csr_src = 0;
    inst_ecall = 0; inst_ebreak = 0; inst_mret = 0;
    exc_valid = 0; exc_cause = 0; exc_tval = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a,
                    input logic [31:0] s);
    valid = 1; csr_op = op; csr_addr = a; csr_src = s;
    tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [11:0] a,
                    input logic [31:0] exp);
    idle();
    csr_addr = a;
    @(negedge clock);
    chk(nm, rdata, 64'(exp));
    tick();
  endtask

  bit [11:0] alist [18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                            12'h342, 12'h343, 12'h344, 12'h180, 12'hB00,
                            12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                            12'h7C0, 12'h000, 12'h301};

  initial begin
    idle();
    reset = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1;
    csr_addr = 12'h300;
    @(negedge clock);
    chk("reset mstatus", rdata, 64'h1800);
    csr_addr = 12'hB00;
    repeat (10) @(posedge clock);
    #1;
    @(negedge clock);
    chk("mcycle after 10", rdata, 64'd10);
    chk("mcycle32 after 10", rdata32, 64'd10);
    tick();

    // timer interrupt aborts the committing instruction
    wr(2'b10, 12'h300, 32'h8);
    wr(2'b01, 12'h304, 32'h80);
    irq_mtip = 1;
    valid = 1; epc = 32'h8000_0100;
    @(negedge clock);
    chk("mtip jump_en", jump_en, 64'd1);
    chk("mtip irq_take", irq_take, 64'd1);
    tick();
    idle(); irq_mtip = 0;
    rd("mtip mcause", 12'h342, 32'h8000_0007);
    rd("mtip mepc", 12'h341, 32'h8000_0100);
    rd("mtip mstatus", 12'h300, 32'h1880);

    // vectored platform interrupt through the synchroniser
    wr(2'b01, 12'h305, 32'h8000_0001);
    wr(2'b01, 12'h304, 32'h0004_0000);
    wr(2'b10, 12'h300, 32'h8);
    valid = 1; epc = 32'h8000_0300; irq_plat = 4'b0100;
    @(negedge clock);
    chk("plat c0 irq_take", irq_take, 64'd0);
    tick();
    @(negedge clock);
    chk("plat c1 irq_take", irq_take, 64'd0);
    tick();
    @(negedge clock);
    chk("plat c2 irq_take", irq_take, 64'd1);
    chk("plat c2 jump", jump, 64'h8000_0048);
    tick();
    idle(); irq_plat = 0;
    rd("plat mcause", 12'h342, 32'h8000_0012);

    // ecall beats a pending interrupt, then mret returns
    wr(2'b01, 12'h304, 32'h800);
    wr(2'b10, 12'h300, 32'h8);
    valid = 1; inst_ecall = 1; irq_meip = 1; epc = 32'h8000_0200;
    @(negedge clock);
    chk("ecall jump_en", jump_en, 64'd1);
    chk("ecall irq_take", irq_take, 64'd0);
    chk("ecall jump", jump, 64'h8000_0000);
    tick();
    idle(); irq_meip = 0;
    rd("ecall mcause", 12'h342, 32'h0000_000B);
    valid = 1; inst_mret = 1;
    @(negedge clock);
    chk("mret jump_en", jump_en, 64'd1);
    chk("mret jump", jump, 64'h8000_0200);
    tick();
    rd("mret mstatus", 12'h300, 32'h1888);

    // counter wrap, 64-bit and 32-bit builds
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_addr = 12'hB80;
    @(negedge clock);
    chk("mcycleh full", rdata, 64'hFFFF_FFFF);
    chk("mcycleh32 zero", rdata32, 64'd0);
    tick();
    csr_addr = 12'hB00;
    @(negedge clock);
    chk("mcycle wrap", rdata, 64'd0);
    chk("mcycle32 wrap", rdata32, 64'd0);
    csr_addr = 12'hB80;
    #1;
    chk("mcycleh wrap", rdata, 64'd0);
    tick();

    // unimplemented address
    valid = 1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_src = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("7C0 illegal", csr_illegal, 64'd1);
    chk("7C0 rdata", rdata, 64'd0);
    tick();
    idle();

    // random phase
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 299) != 0);
      idle();
      valid = $urandom_range(0, 1) == 1;
      csr_addr = alist[$urandom_range(0, 17)];
      csr_op = 2'($urandom_range(0, 3));
      csr_src = $urandom_range(0, 3) == 0 ? 32'h8 : $urandom;
      epc = $urandom;
      r = $urandom_range(0, 15);
      if (r == 0) inst_ecall = 1;
      if (r == 1) inst_ebreak = 1;
      if (r == 2) begin
        exc_valid = 1; exc_cause = 5'($urandom); exc_tval = $urandom;
      end
      if (r == 3) begin inst_mret = 1; csr_op = 0; end
      irq_meip = $urandom_range(0, 5) == 0;
      irq_mtip = $urandom_range(0, 5) == 0;
      irq_msip = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 3) == 0)
        irq_plat[$urandom_range(0, NIRQ-1)] ^= 1'b1;
      tick();
    end
    idle();
    reset = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
